// File: rtl/sync_decoder_pkg.sv
// Shared definitions for the sync decoder: tracking-state encoding, default
// counter widths and the System86 nominal raster dimensions.
package sync_decoder_pkg;

  // Default counter widths
  localparam int unsigned H_W_DEF = 9;
  localparam int unsigned V_W_DEF = 9;

  // System86 nominal raster: clocks per line, lines per frame
  localparam int unsigned H_TOTAL_NOM = 384;
  localparam int unsigned V_TOTAL_NOM = 264;

  // Timing-tracking state
  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } sync_state_t;

endpackage

// File: rtl/sync_decoder_if.sv
// Video timing receive bundle: raw HSYNC/VSYNC plus the recovered position,
// measured line/frame lengths and status pulses.
//   master : timing source / observer (drives syncs, reads results)
//   slave  : sync_decoder (reads syncs, drives results)
interface sync_decoder_if
  import sync_decoder_pkg::*;
#(
  parameter int unsigned H_W = H_W_DEF,
  parameter int unsigned V_W = V_W_DEF
);

  logic           HSYNC;
  logic           VSYNC;
  logic [H_W-1:0] H_CNT;
  logic [V_W-1:0] V_CNT;
  logic [H_W-1:0] H_TOTAL;
  logic [V_W-1:0] V_TOTAL;
  logic           NEW_LINE;
  logic           NEW_FRAME;
  logic           LOCKED;
  logic           TIMEOUT;

  modport master (
    output HSYNC, VSYNC,
    input  H_CNT, V_CNT, H_TOTAL, V_TOTAL, NEW_LINE, NEW_FRAME, LOCKED, TIMEOUT
  );

  modport slave (
    input  HSYNC, VSYNC,
    output H_CNT, V_CNT, H_TOTAL, V_TOTAL, NEW_LINE, NEW_FRAME, LOCKED, TIMEOUT
  );

endinterface

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer followed by an edge-history flop; flags the rising
// edge of an asynchronous input.
//   clk    : sampling clock
//   rst_n  : async active-low reset
//   din    : asynchronous level input
//   rise_c : combinational one-cycle rising-edge flag (from flops only)
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise_c
);

  // sr[0], sr[1]: synchronizer; sr[2]: previous synchronized level
  logic [2:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= 3'b000;
    end else begin
      sr <= {sr[1:0], din};
    end
  end

  assign rise_c = sr[1] & ~sr[2];

endmodule

// File: rtl/sync_decoder.sv
// Video sync receiver: recovers beam position from HSYNC/VSYNC, measures line
// and frame lengths, and tracks line-length stability to declare lock.
//   CLK_6M : pixel clock
//   RST_N  : async active-low reset
//   bus    : sync_decoder_if.slave (HSYNC/VSYNC in; counters, totals,
//            NEW_LINE/NEW_FRAME/TIMEOUT pulses and LOCKED out)
module sync_decoder
  import sync_decoder_pkg::*;
#(
  parameter int unsigned H_W        = H_W_DEF,
  parameter int unsigned V_W        = V_W_DEF,
  parameter int unsigned H_MAX      = 511,
  parameter int unsigned LOCK_LINES = 4,
  parameter int unsigned MISS_LIMIT = 2
) (
  input  logic          CLK_6M,
  input  logic          RST_N,
  sync_decoder_if.slave bus
);

  localparam int unsigned LC_W = $clog2(LOCK_LINES + 1);
  localparam int unsigned MC_W = $clog2(MISS_LIMIT + 1);

  localparam logic [H_W-1:0] H_MAX_V = H_W'(H_MAX);
  localparam logic [H_W-1:0] H_PRE_V = H_W'(H_MAX - 1);
  localparam logic [V_W-1:0] V_SAT_V = '1;

  // Synchronized edge events (valid the cycle before the output pulses)
  logic line_c;
  logic frame_c;
  logic to_c;

  logic [H_W-1:0] h_cnt;
  logic [H_W-1:0] h_total;
  logic [H_W-1:0] h_len_c;
  logic           timed_out_c;
  logic [V_W-1:0] v_cnt;
  logic [V_W-1:0] v_total;
  logic           new_line;
  logic           new_frame;
  logic           timeout;
  logic           locked;

  sync_state_t     state, state_nx;
  logic [LC_W-1:0] lock_cnt, lock_cnt_nx, lock_inc_c;
  logic [MC_W-1:0] miss_cnt, miss_cnt_nx, miss_inc_c;
  // Line length captured on entering LOCKED; a single odd line while locked
  // must not redefine what counts as a matching line.
  logic [H_W-1:0]  lock_len, lock_len_nx;

  // HSYNC / VSYNC synchronizers
  sync_edge_detect u_hs_edge (
    .clk    (CLK_6M),
    .rst_n  (RST_N),
    .din    (bus.HSYNC),
    .rise_c (line_c)
  );

  sync_edge_detect u_vs_edge (
    .clk    (CLK_6M),
    .rst_n  (RST_N),
    .din    (bus.VSYNC),
    .rise_c (frame_c)
  );

  // Length of the line being closed if a line edge lands now
  assign h_len_c     = h_cnt + H_W'(1);
  // H_CNT sits at H_MAX only after the line has timed out
  assign timed_out_c = (h_cnt == H_MAX_V);
  // Timeout fires on the step into H_MAX, never while holding there
  assign to_c        = (h_cnt == H_PRE_V) && !line_c;

  assign lock_inc_c  = lock_cnt + LC_W'(1);
  assign miss_inc_c  = miss_cnt + MC_W'(1);

  // Position counters, measured totals and registered pulses
  always_ff @(posedge CLK_6M or negedge RST_N) begin
    if (!RST_N) begin
      h_cnt     <= '0;
      h_total   <= '0;
      v_cnt     <= '0;
      v_total   <= '0;
      new_line  <= 1'b0;
      new_frame <= 1'b0;
      timeout   <= 1'b0;
      locked    <= 1'b0;
    end else begin
      new_line  <= line_c;
      new_frame <= frame_c;
      timeout   <= to_c;
      locked    <= (state == ST_LOCKED);

      if (line_c) begin
        h_cnt <= '0;
        if (!timed_out_c) begin
          h_total <= h_len_c;
        end
      end else if (!timed_out_c) begin
        h_cnt <= h_len_c;
      end

      // Frame edge wins over a coincident line edge for V_CNT
      if (frame_c) begin
        v_cnt   <= '0;
        v_total <= v_cnt + V_W'(1);
      end else if (line_c && (v_cnt != V_SAT_V)) begin
        v_cnt <= v_cnt + V_W'(1);
      end
    end
  end

  // Tracking state register
  always_ff @(posedge CLK_6M or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_SEARCH;
      lock_cnt <= '0;
      miss_cnt <= '0;
      lock_len <= '0;
    end else begin
      state    <= state_nx;
      lock_cnt <= lock_cnt_nx;
      miss_cnt <= miss_cnt_nx;
      lock_len <= lock_len_nx;
    end
  end

  // Tracking next-state: only line edges and timeouts move the FSM
  always_comb begin
    state_nx    = state;
    lock_cnt_nx = lock_cnt;
    miss_cnt_nx = miss_cnt;
    lock_len_nx = lock_len;

    unique case (state)
      ST_SEARCH: begin
        if (line_c && !timed_out_c) begin
          state_nx    = ST_TRACK;
          lock_cnt_nx = LC_W'(1);
          miss_cnt_nx = '0;
        end
      end

      ST_TRACK: begin
        if (to_c) begin
          state_nx    = ST_SEARCH;
          lock_cnt_nx = '0;
        end else if (line_c) begin
          if (h_len_c == h_total) begin
            if (32'(lock_inc_c) >= LOCK_LINES) begin
              state_nx    = ST_LOCKED;
              lock_cnt_nx = '0;
              miss_cnt_nx = '0;
              lock_len_nx = h_len_c;
            end else begin
              lock_cnt_nx = lock_inc_c;
            end
          end else begin
            lock_cnt_nx = LC_W'(1);
          end
        end
      end

      ST_LOCKED: begin
        if (to_c) begin
          state_nx    = ST_SEARCH;
          miss_cnt_nx = '0;
        end else if (line_c) begin
          if (h_len_c == lock_len) begin
            miss_cnt_nx = '0;
          end else if (32'(miss_inc_c) >= MISS_LIMIT) begin
            state_nx    = ST_SEARCH;
            miss_cnt_nx = '0;
          end else begin
            miss_cnt_nx = miss_inc_c;
          end
        end
      end

      default: begin
        state_nx    = ST_SEARCH;
        lock_cnt_nx = '0;
        miss_cnt_nx = '0;
      end
    endcase
  end

  assign bus.H_CNT     = h_cnt;
  assign bus.V_CNT     = v_cnt;
  assign bus.H_TOTAL   = h_total;
  assign bus.V_TOTAL   = v_total;
  assign bus.NEW_LINE  = new_line;
  assign bus.NEW_FRAME = new_frame;
  assign bus.TIMEOUT   = timeout;
  assign bus.LOCKED    = locked;

endmodule

// File: doc/sync_decoder.md
Name: sync_decoder

Overview:
- Receiver side of the video timing interface. Consumes the HSYNC/VSYNC pair that the timing subsystem drives.
- Recovers the horizontal and vertical beam position, measures line and frame lengths, and declares lock once the timing is stable.
- Used by the capture/scaler and monitor-emulation paths, and by the bench to check the timing generator's output.
- Runs on the pixel clock: one count per CLK_6M cycle.

Parameters:
- H_W, 9, width of horizontal counter and H_TOTAL.
- V_W, 9, width of vertical counter and V_TOTAL.
- H_MAX, 511, H_CNT value at which a missing HSYNC is declared (line timeout).
- LOCK_LINES, 4, consecutive equal-length lines needed to enter LOCKED.
- MISS_LIMIT, 2, consecutive mismatched lines in LOCKED that force return to SEARCH.

Ports:
- CLK_6M  in  1  pixel clock; the only clock.
- RST_N  in  1  asynchronous, active-low reset.
- HSYNC  in  1  horizontal sync, active high, asynchronous to CLK_6M.
- VSYNC  in  1  vertical sync, active high, asynchronous to CLK_6M.
- H_CNT  out  H_W  pixels since last detected HSYNC rising edge.
- V_CNT  out  V_W  lines since last detected VSYNC rising edge.
- H_TOTAL  out  H_W  length of last complete line, in clocks.
- V_TOTAL  out  V_W  length of last complete frame, in lines.
- NEW_LINE  out  1  one-cycle pulse on detected HSYNC rising edge.
- NEW_FRAME  out  1  one-cycle pulse on detected VSYNC rising edge.
- LOCKED  out  1  high in LOCKED state.
- TIMEOUT  out  1  one-cycle pulse when H_CNT reaches H_MAX.

Behaviour:
- Reset (RST_N low, asynchronous): all outputs 0, synchronizers 0, state SEARCH, lock/miss counters 0.
- Input path: HSYNC and VSYNC each pass through a 2-flop synchronizer and a third edge-detect flop.
- NEW_LINE and NEW_FRAME assert 3 clocks after the input rising edge. Falling edges are ignored.
- H_CNT:
  - Loads 0 in the NEW_LINE cycle.
  - Otherwise increments by 1.
  - At H_MAX it holds and pulses TIMEOUT once (the pulse does not repeat while holding).
- H_TOTAL: on NEW_LINE, loads H_CNT+1, truncated to H_W. Not loaded if the line timed out; it keeps its old value.
- V_CNT:
  - Loads 0 on NEW_FRAME.
  - Else increments on NEW_LINE, saturating at 2^V_W-1.
- V_TOTAL: on NEW_FRAME, loads V_CNT+1. When NEW_FRAME and NEW_LINE coincide, V_CNT+1 is still used and V_CNT goes to 0.
- Simultaneous edges: NEW_FRAME has priority for V_CNT. H_CNT behaves as for NEW_LINE.
- State machine (evaluated on NEW_LINE or TIMEOUT only):
  - SEARCH: on the first NEW_LINE with no prior timeout, go to TRACK with lock count 1.
  - TRACK:
    - On NEW_LINE with H_CNT+1 == H_TOTAL, increment lock count. Reaching LOCK_LINES moves to LOCKED.
    - On NEW_LINE with a mismatch, lock count = 1 and stay in TRACK.
    - On TIMEOUT, go to SEARCH.
  - LOCKED:
    - A matching line clears the miss count.
    - A mismatch increments the miss count. Reaching MISS_LIMIT goes to SEARCH.
    - On TIMEOUT, go to SEARCH immediately.
    - H_TOTAL updates on every NEW_LINE regardless of state.
- LOCKED is a registered output, high the cycle after the state transition.
- Reset mid-line or mid-frame: counters clear immediately; measurement restarts from SEARCH.

Decomposition:
- Shared package:
  - State encoding: SEARCH=2'd0, TRACK=2'd1, LOCKED=2'd2.
  - System86 nominal constants: H_TOTAL_NOM=384, V_TOTAL_NOM=264.
  - H_W and V_W defaults.
- One sub-module, sync_edge_detect: 2-flop synchronizer plus rising-edge pulse, instantiated twice (HSYNC and VSYNC).

Test Plan:
- Reset release, then HSYNC pulses every 384 clocks:
  - First NEW_LINE 3 clocks after the first rising edge.
  - H_TOTAL = 384 after the second line.
  - LOCKED high after the 5th NEW_LINE (1 to enter TRACK, 4 matching).
- Locked at 384, then one line of 380 followed by 384 → miss count 1, LOCKED stays high, H_TOTAL = 380 then 384.
- Locked, then HSYNC stopped → H_CNT holds at 511, TIMEOUT pulses exactly once, LOCKED drops the cycle after TIMEOUT.
- VSYNC every 264 lines, rising in the same clock as HSYNC → NEW_FRAME and NEW_LINE pulse together; V_CNT = 0; V_TOTAL = 264.
- RST_N asserted mid-line at H_CNT=200 → all outputs 0 asynchronously; after release, state SEARCH and LOCKED low.
- HSYNC changing 1 ns before a CLK_6M edge → exactly one NEW_LINE pulse per rising edge; no double pulse; latency 3 or 4 clocks.
